// File: rtl/fp_mul_issuer.sv
// Initiator side of the FP16 multiplier handshake: issues operand pairs, collects results into a show-ahead FIFO.
// Optional FP_ISSUER_STATS_EN adds issue_cnt/done_cnt counters.
module fp_mul_issuer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] mul_A,
  output logic [15:0] mul_B,
  output logic        mul_Ready,
  input  logic [15:0] mul_C,
  input  logic        mul_Valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_c,
  input  logic        flush,
  output logic        busy,
  output logic        err
`ifdef FP_ISSUER_STATS_EN
  ,
  output logic [31:0] issue_cnt,
  output logic [31:0] done_cnt
`endif
);

  localparam int unsigned DW = 16;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned KW = CW + 1;
  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   inflight_q;
  logic [CW-1:0]   fifo_cnt_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [WW-1:0]   wd_q;
  logic            err_q;

  logic [KW-1:0]   credit_c;
  logic            accept_c;
  logic            ret_c;
  logic            spurious_c;
  logic            pop_c;
  logic            push_c;
  logic            clear_c;
  logic            stalled_c;

  // Space not yet claimed by buffered results or outstanding operations.
  assign credit_c   = KW'(DEPTH) - KW'(fifo_cnt_q) - KW'(inflight_q);
  assign in_ready   = rst_n && (state_q == ST_RUN) && !err_q && (credit_c != '0)
                      && (inflight_q < IW'(MAX_INFLIGHT));
  assign accept_c   = in_valid && in_ready;
  assign ret_c      = mul_Valid && (inflight_q != '0);
  assign spurious_c = mul_Valid && (inflight_q == '0);
  assign pop_c      = out_valid && out_ready;
  assign push_c     = ret_c && ((fifo_cnt_q != CW'(DEPTH)) || pop_c);
  assign clear_c    = (state_q == ST_CLEAR);
  assign stalled_c  = (inflight_q != '0) && !mul_Valid;

  assign out_valid  = (fifo_cnt_q != '0);
  assign out_c      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign busy       = (inflight_q != '0) || out_valid;
  assign err        = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (flush) state_q <= ST_FLUSH;
        ST_FLUSH: if (inflight_q == '0) state_q <= ST_CLEAR;
        ST_CLEAR: if (!flush) state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  // Operand issue: one Ready pulse per accepted pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_A     <= '0;
      mul_B     <= '0;
      mul_Ready <= 1'b0;
    end else begin
      mul_Ready <= accept_c;
      if (accept_c) begin
        mul_A <= in_a;
        mul_B <= in_b;
      end
    end
  end

  // Reservation is taken at accept so credit already covers the result slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_q + IW'(accept_c) - IW'(ret_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (clear_c) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      fifo_cnt_q <= fifo_cnt_q + CW'(push_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= mul_C;
  end

  // Watchdog on a silent multiplier plus sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (!stalled_c) begin
        wd_q <= '0;
      end else if (wd_q != WW'(TIMEOUT)) begin
        wd_q <= wd_q + WW'(1);
      end
      if (spurious_c || (stalled_c && (wd_q == WW'(TIMEOUT - 1)))) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef FP_ISSUER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      done_cnt  <= '0;
    end else begin
      if (accept_c) issue_cnt <= issue_cnt + 32'd1;
      if (ret_c)    done_cnt  <= done_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_issuer.sv
// Scoreboard bench for fp_mul_issuer with a behavioural fixed-latency FP16 multiplier.
module tb_fp_mul_issuer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] mul_A;
  logic [15:0] mul_B;
  logic        mul_Ready;
  logic [15:0] mul_C;
  logic        mul_Valid;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_c;
  logic        flush;
  logic        busy;
  logic        err;
`ifdef FP_ISSUER_STATS_EN
  logic [31:0] issue_cnt;
  logic [31:0] done_cnt;
`endif

  int          checks;
  int          errors;
  logic [15:0] exp_q [$];
  logic        stall;
  int          inj_req;

  localparam logic [15:0] ORD_A [4] = '{16'hC000, 16'hC000, 16'h0000, 16'h7C00};
  localparam logic [15:0] ORD_B [4] = '{16'h4200, 16'hC200, 16'h4200, 16'h4200};
  localparam logic [15:0] ORD_E [4] = '{16'hC600, 16'h4600, 16'h0000, 16'h7C00};
  localparam logic [15:0] BP_A  [6] = '{16'h3C00, 16'h4000, 16'h4200, 16'h3C00, 16'h3800, 16'h4000};
  localparam logic [15:0] BP_B  [6] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4000, 16'h4000, 16'h4200};
  localparam logic [15:0] BP_E  [6] = '{16'h3C00, 16'h4400, 16'h4880, 16'h4000, 16'h3C00, 16'h4600};
  localparam logic [15:0] SIM_A [4] = '{16'hC000, 16'h3C00, 16'h4200, 16'h0000};
  localparam logic [15:0] SIM_B [4] = '{16'h4200, 16'h3C00, 16'h4200, 16'h4200};
  localparam logic [15:0] SIM_E [4] = '{16'hC600, 16'h3C00, 16'h4880, 16'h0000};

  fp_mul_issuer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_A     (mul_A),
    .mul_B     (mul_B),
    .mul_Ready (mul_Ready),
    .mul_C     (mul_C),
    .mul_Valid (mul_Valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .flush     (flush),
    .busy      (busy),
    .err       (err)
`ifdef FP_ISSUER_STATS_EN
    ,
    .issue_cnt (issue_cnt),
    .done_cnt  (done_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  // Hand-computed FP16 products for every operand pair the bench issues.
  function automatic logic [15:0] fp_prod(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h4000_4200: return 16'h4600;
      32'hC000_4200: return 16'hC600;
      32'hC000_C200: return 16'h4600;
      32'h0000_4200: return 16'h0000;
      32'h7C00_4200: return 16'h7C00;
      32'h3C00_3C00: return 16'h3C00;
      32'h4000_4000: return 16'h4400;
      32'h4200_4200: return 16'h4880;
      32'h3C00_4000: return 16'h4000;
      32'h3800_4000: return 16'h3C00;
      32'h7BFF_7BFF: return 16'h7C00;
      default:       return 16'hDEAD;
    endcase
  endfunction

  // Multiplier: result strobe lands on the 4th rising edge after the Ready edge.
  initial begin
    int          cyc;
    int          inj_done;
    int          due_q [$];
    logic [15:0] res_q [$];
    cyc = 0;
    inj_done = 0;
    mul_Valid = 1'b0;
    mul_C = 16'h0;
    forever begin
      @(negedge clk);
      cyc++;
      mul_Valid = 1'b0;
      mul_C = 16'h0;
      if (!rst_n) begin
        due_q.delete();
        res_q.delete();
      end else begin
        if (mul_Ready) begin
          due_q.push_back(cyc + 3);
          res_q.push_back(fp_prod(mul_A, mul_B));
        end
        if (inj_req != inj_done) begin
          inj_done++;
          mul_Valid = 1'b1;
          mul_C = 16'h1234;
        end else if (!stall && due_q.size() > 0 && due_q[0] <= cyc) begin
          void'(due_q.pop_front());
          mul_C = res_q.pop_front();
          mul_Valid = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Result monitor: every handshake pops one expected value.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got %0h, required no output", out_c);
        end else begin
          e = exp_q.pop_front();
          chk("out_c", out_c, e);
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e,
                      input int budget, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < budget && !ok; i++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        exp_q.push_back(e);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (n < 40 && (exp_q.size() != 0 || busy)) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, 32'((exp_q.size() == 0) && !busy), 32'd1);
  endtask

  initial begin
    bit ok;
    int n;
    int lat;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = 16'h0;
    in_b = 16'h0;
    out_ready = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    inj_req = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mul_ready", mul_Ready, 0);
    chk("rst_mul_a", mul_A, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_c", out_c, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_after_rst", in_ready, 1);

    // Single operation
    @(negedge clk);
    out_ready = 1'b1;
    send(16'h4000, 16'h4200, 16'h4600, 4, ok);
    chk("single_accept", ok, 1);
    #1;
    chk("single_ready_pulse", mul_Ready, 1);
    chk("single_mul_a", mul_A, 16'h4000);
    chk("single_mul_b", mul_B, 16'h4200);
    @(negedge clk);
    #1;
    chk("single_ready_width", mul_Ready, 0);
    lat = 1;
    while (lat < 20 && !out_valid) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("single_latency", lat, 4);
    drain("single_drain");
    chk("single_busy_idle", busy, 0);

    // Back-to-back ordering stream
    for (int i = 0; i < 4; i++) begin
      send(ORD_A[i], ORD_B[i], ORD_E[i], 1, ok);
      chk("order_accept", ok, 1);
      #1 chk("order_ready_pulse", mul_Ready, 1);
    end
    drain("order_drain");

    // Backpressure: only DEPTH results may be outstanding
    @(negedge clk);
    out_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      send(BP_A[i], BP_B[i], BP_E[i], 2, ok);
      if (ok) n++;
    end
    chk("bp_accepts", n, 4);
    repeat (6) @(negedge clk);
    #1;
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1 chk("bp_in_ready_after_pop", in_ready, 1);
    n = 0;
    for (int i = 4; i < 6; i++) begin
      send(BP_A[i], BP_B[i], BP_E[i], 2, ok);
      if (ok) n++;
    end
    chk("bp_extra_accepts", n, 1);
    repeat (6) @(negedge clk);
    #1 chk("bp_in_ready_refull", in_ready, 0);
    drain("bp_drain");

    // Pop and return on the same edge
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(SIM_A[i], SIM_B[i], SIM_E[i], 2, ok);
      chk("sim_accept", ok, 1);
    end
    repeat (8) @(negedge clk);
    send(SIM_A[3], SIM_B[3], SIM_E[3], 2, ok);
    chk("sim_accept_last", ok, 1);
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("sim_in_ready", in_ready, 1);
    chk("sim_out_valid", out_valid, 1);
    drain("sim_drain");

    // Flush with two in flight and one buffered
    @(negedge clk);
    out_ready = 1'b0;
    send(16'h4000, 16'h4000, 16'h4400, 2, ok);
    repeat (6) @(negedge clk);
    send(16'h3C00, 16'h4000, 16'h4000, 2, ok);
    send(16'h3800, 16'h4000, 16'h3C00, 2, ok);
    flush = 1'b1;
    @(negedge clk);
    #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_busy", busy, 1);
    n = 0;
    while (n < 20 && busy) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("flush_complete", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_err", err, 0);
    chk("flush_hold_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1 chk("flush_release_in_ready", in_ready, 1);
    send(16'h4000, 16'h4200, 16'h4600, 2, ok);
    chk("post_flush_accept", ok, 1);
    drain("post_flush_drain");

    // Spurious result strobe
    @(negedge clk);
    inj_req = inj_req + 1;
    repeat (3) @(negedge clk);
    #1;
    chk("spurious_err", err, 1);
    chk("spurious_not_pushed", out_valid, 0);
    chk("spurious_busy", busy, 0);
    chk("spurious_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_clears_err", err, 0);
    chk("rst_in_ready_again", in_ready, 1);

    // Stalled multiplier trips the watchdog
    @(negedge clk);
    stall = 1'b1;
    send(16'h7BFF, 16'h7BFF, 16'h7C00, 2, ok);
    chk("wd_accept", ok, 1);
    repeat (10) @(negedge clk);
    #1 chk("wd_early", err, 0);
    repeat (10) @(negedge clk);
    #1;
    chk("wd_timeout", err, 1);
    chk("wd_in_ready", in_ready, 0);
    send(16'h4000, 16'h4200, 16'h4600, 3, ok);
    chk("wd_reject", ok, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    stall = 1'b0;
    exp_q.delete();
    rst_n = 1'b1;
    #1;
    chk("wd_rst_err", err, 0);
    chk("wd_rst_busy", busy, 0);

    repeat (3) @(negedge clk);
    chk("end_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
